// File: rtl/pc_sequencer.sv
// Program-counter control FSM: fetch/decode/execute sequencing with a return-address stack.
// Outputs are registered for the state being entered; the decoder is stalled by holding DECODE until op_valid.
module pc_sequencer #(
  parameter int              AW          = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [AW-1:0]   RESET_VEC   = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           halt_req,
  input  logic [AW-1:0]                  pc_val,
  input  logic                           fetch_ack,
  input  logic                           op_valid,
  input  logic [2:0]                     op_kind,
  input  logic [AW-1:0]                  op_target,
  output logic                           pc_en,
  output logic                           pc_load,
  output logic [AW-1:0]                  pc_load_val,
  output logic                           pc_oe,
  output logic                           fetch_req,
  output logic                           busy,
  output logic                           fault,
  output logic [$clog2(STACK_DEPTH):0]   stack_level
);

  localparam int SW = $clog2(STACK_DEPTH);
  localparam int LW = SW + 1;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_DECODE, S_EXEC, S_HALTED, S_FAULT
  } state_t;

  state_t        state;
  logic [2:0]    op_kind_q;
  logic [AW-1:0] op_target_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] stack_mem [STACK_DEPTH];

  logic          stack_full;
  logic          stack_empty;
  logic [SW-1:0] top_idx;
  logic [SW-1:0] push_idx;

  assign stack_full  = (stack_level == LW'(STACK_DEPTH));
  assign stack_empty = (stack_level == '0);
  assign top_idx     = SW'(stack_level - LW'(1));
  assign push_idx    = stack_level[SW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stack_level <= '0;
      pc_en       <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      pc_oe       <= 1'b0;
      fetch_req   <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      op_kind_q   <= '0;
      op_target_q <= '0;
      pc_q        <= '0;
    end else begin
      pc_en     <= 1'b0;
      pc_load   <= 1'b0;
      pc_oe     <= 1'b0;
      fetch_req <= 1'b0;
      busy      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_START;
            pc_load     <= 1'b1;
            pc_load_val <= RESET_VEC;
            busy        <= 1'b1;
          end
        end
        S_START: begin
          state     <= S_FETCH;
          fetch_req <= 1'b1;
          pc_oe     <= 1'b1;
          busy      <= 1'b1;
        end
        S_FETCH: begin
          // A halt request wins even when the fetch completes this cycle.
          if (halt_req) begin
            state <= S_HALTED;
          end else if (fetch_ack) begin
            state <= S_DECODE;
            pc_oe <= 1'b1;
            busy  <= 1'b1;
          end else begin
            fetch_req <= 1'b1;
            pc_oe     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_DECODE: begin
          busy <= 1'b1;
          if (op_valid) begin
            state       <= S_EXEC;
            op_kind_q   <= op_kind;
            op_target_q <= op_target;
            pc_q        <= pc_val;
            // EXEC strobes are prepared here so they appear during the EXEC cycle.
            case (op_kind)
              OP_NEXT: pc_en <= 1'b1;
              OP_JUMP: begin
                pc_load     <= 1'b1;
                pc_load_val <= op_target;
              end
              OP_CALL: begin
                if (!stack_full) begin
                  pc_load     <= 1'b1;
                  pc_load_val <= op_target;
                end else begin
                  fault <= 1'b1;
                end
              end
              OP_RET: begin
                if (!stack_empty) begin
                  pc_load     <= 1'b1;
                  pc_load_val <= stack_mem[top_idx];
                end else begin
                  fault <= 1'b1;
                end
              end
              OP_HALT: ;
              default: fault <= 1'b1;
            endcase
          end else begin
            pc_oe <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_kind_q)
            OP_NEXT, OP_JUMP: begin
              state     <= S_FETCH;
              fetch_req <= 1'b1;
              pc_oe     <= 1'b1;
              busy      <= 1'b1;
            end
            OP_CALL: begin
              if (!stack_full) begin
                stack_mem[push_idx] <= pc_q + AW'(1);
                stack_level         <= stack_level + LW'(1);
                state               <= S_FETCH;
                fetch_req           <= 1'b1;
                pc_oe               <= 1'b1;
                busy                <= 1'b1;
              end else begin
                state <= S_FAULT;
              end
            end
            OP_RET: begin
              if (!stack_empty) begin
                stack_level <= stack_level - LW'(1);
                state       <= S_FETCH;
                fetch_req   <= 1'b1;
                pc_oe       <= 1'b1;
                busy        <= 1'b1;
              end else begin
                state <= S_FAULT;
              end
            end
            OP_HALT: state <= S_HALTED;
            default: state <= S_FAULT;
          endcase
        end
        S_HALTED: begin
          if (start) begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
            pc_oe     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FAULT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
